// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store unit driving a 64-bit doubleword data memory
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] Read_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [63:0] base_q;
    logic [2:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [63:0] wdata_q;
    logic [63:0] rmw_q;

    logic [2:0]  align_mask;
    logic        req_err;
    logic [5:0]  shift;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] field;
    logic [63:0] load_ext;
    logic [63:0] merged;

    // Low address bits that must be zero for the requested access size.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign req_err = (|(req_addr[2:0] & align_mask))
                   || (req_addr >= 64'(MEM_BYTES))
                   || (!req_write && req_funct3 == 3'b111)
                   || (req_write && req_funct3[2]);

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign shift     = {lane_q, 3'b000};
    assign lane_mask = size_mask << shift;
    assign field     = Read_Data >> shift;
    assign merged    = (rmw_q & ~lane_mask) | ((wdata_q << shift) & lane_mask);

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{56{field[7]}},  field[7:0]};
            3'b001:  load_ext = {{48{field[15]}}, field[15:0]};
            3'b010:  load_ext = {{32{field[31]}}, field[31:0]};
            3'b011:  load_ext = field;
            3'b100:  load_ext = {56'd0, field[7:0]};
            3'b101:  load_ext = {48'd0, field[15:0]};
            3'b110:  load_ext = {32'd0, field[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)                    state_next = S_DONE;
                    else if (!req_write)            state_next = S_LOAD;
                    else if (req_funct3[1:0] == 2'b11) state_next = S_WRITE;
                    else                            state_next = S_RMW_RD;
                end
            end
            S_LOAD:   state_next = S_DONE;
            S_WRITE:  state_next = S_DONE;
            S_RMW_RD: state_next = S_RMW_WR;
            S_RMW_WR: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            base_q     <= '0;
            lane_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            rmw_q      <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && req_valid) begin
                base_q   <= {req_addr[63:3], 3'b000};
                lane_q   <= req_addr[2:0];
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (state == S_RMW_RD) begin
                rmw_q <= Read_Data;
            end
            // Response fields only change on entry to DONE and then hold.
            if (state_next == S_DONE) begin
                resp_error <= (state == S_IDLE);
                resp_rdata <= (state == S_LOAD) ? load_ext : 64'd0;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign MemRead    = (state == S_LOAD)  || (state == S_RMW_RD);
    assign MemWrite   = (state == S_WRITE) || (state == S_RMW_WR);
    assign Mem_Addr   = (MemRead || MemWrite) ? base_q : 64'd0;

    always_comb begin
        case (state)
            S_WRITE:  Write_Data = wdata_q;
            S_RMW_WR: Write_Data = merged;
            default:  Write_Data = 64'd0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a doubleword memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_Data  (Read_Data)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem[0:63];
    logic [7:0]  ref_save[0:63];
    logic [63:0] mem_dw[0:7];
    logic        preload = 1'b1;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int acc_count = 0;
    int last_acc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [63:0] last_raddr = '0;
    logic [63:0] last_waddr = '0;
    logic [63:0] last_wdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_dw(input int i);
        logic [63:0] v;
        for (int j = 0; j < 8; j++) v[8*j +: 8] = ref_mem[8*i + j];
        return v;
    endfunction

    // Memory seen by the DUT: preloaded once, then written only through MemWrite.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    mem_dw[i][8*j +: 8] <= 8'((8*i + j) * 3 + 1);
        end else if (MemWrite) begin
            mem_dw[Mem_Addr[5:3]] <= Write_Data;
        end
    end

    assign Read_Data = MemRead ? mem_dw[Mem_Addr[5:3]] : 64'd0;

    task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input int acc);
        exp_t        e;
        int          size;
        logic [63:0] v;
        size    = 1 << f3[1:0];
        e.err   = (a % size != 0) || (a >= 64) || (!w && f3 == 3'b111) || (w && f3[2]);
        e.rdata = '0;
        e.acc   = acc;
        if (e.err)                 e.lat = 1;
        else if (!w || size == 8)  e.lat = 2;
        else                       e.lat = 3;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
                if (!f3[2] && size < 8 && v[8*size-1])
                    for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        sb.push_back(e);
    endtask

    // Acceptance observer: sees the handshake at the edge and feeds the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            if (reset_n && req_valid && req_ready) begin
                acc_count++;
                last_acc = cycle;
                model(req_write, req_funct3, req_addr, req_wdata, cycle);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (MemRead || MemWrite) check("rw_exclusive", 64'(MemRead && MemWrite), 64'd0);
            if (MemRead) begin
                rd_cnt++;
                last_raddr = Mem_Addr;
            end
            if (MemWrite) begin
                wr_cnt++;
                last_waddr = Mem_Addr;
                last_wdata = Write_Data;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_error", 64'(resp_error), 64'(e.err));
                    check("resp_latency", 64'(cycle - e.acc + 1), 64'(e.lat));
                end
            end
        end
    end

    task automatic scramble();
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        int n0;
        n0 = acc_count;
        @(negedge clk);
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        for (int k = 0; k < 20 && acc_count == n0; k++) @(negedge clk);
        if (acc_count == n0) check("accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30 && (sb.size() != 0 || !req_ready); k++) @(negedge clk);
        if (sb.size() != 0 || !req_ready) check("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int r0, w0, n0, acc1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 3 + 1);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_memread", 64'(MemRead), 64'd0);
        check("rst_memwrite", 64'(MemWrite), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_mem_addr", Mem_Addr, 64'd0);
        check("rst_write_data", Write_Data, 64'd0);
        preload = 1'b0;
        reset_n = 1'b1;

        // sd then ld
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 3'b011, 64'd8, 64'h1122334455667788);
        wait_idle();
        check("sd_write_cycles", 64'(wr_cnt - w0), 64'd1);
        check("sd_read_cycles", 64'(rd_cnt - r0), 64'd0);
        check("sd_mem_addr", last_waddr, 64'd8);
        check("sd_write_data", last_wdata, 64'h1122334455667788);
        issue(1'b0, 3'b011, 64'd8, 64'd0);

        // load extension
        issue(1'b0, 3'b000, 64'd8, 64'd0);
        issue(1'b0, 3'b100, 64'd8, 64'd0);
        issue(1'b0, 3'b001, 64'd14, 64'd0);
        issue(1'b0, 3'b010, 64'd12, 64'd0);
        issue(1'b0, 3'b101, 64'd10, 64'd0);
        issue(1'b0, 3'b110, 64'd12, 64'd0);
        wait_idle();

        // narrow store
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 3'b000, 64'd9, 64'hFFFF_FFFF_FFFF_FFAB);
        wait_idle();
        check("sb_read_cycles", 64'(rd_cnt - r0), 64'd1);
        check("sb_read_addr", last_raddr, 64'd8);
        check("sb_write_cycles", 64'(wr_cnt - w0), 64'd1);
        check("sb_write_data", last_wdata, 64'h112233445566AB88);
        issue(1'b0, 3'b011, 64'd8, 64'd0);
        wait_idle();

        // error requests
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b0, 3'b010, 64'd6, 64'd0);
        issue(1'b0, 3'b011, 64'd64, 64'd0);
        issue(1'b0, 3'b111, 64'd8, 64'd0);
        issue(1'b1, 3'b100, 64'd8, 64'hDEAD);
        wait_idle();
        check("err_read_cycles", 64'(rd_cnt - r0), 64'd0);
        check("err_write_cycles", 64'(wr_cnt - w0), 64'd0);
        check("err_mem_dw1", mem_dw[1], ref_dw(1));

        // reset in the middle of a read-modify-write
        ref_save = ref_mem;
        w0 = wr_cnt;
        @(negedge clk);
        req_write = 1'b1; req_funct3 = 3'b001; req_addr = 64'd16; req_wdata = 64'hBEEF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_memread", 64'(MemRead), 64'd1);
        check("rmw_rd_addr", Mem_Addr, 64'd16);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_memwrite", 64'(MemWrite), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ref_mem = ref_save;
        sb.delete();
        repeat (3) @(negedge clk);
        check("midrst_write_cycles", 64'(wr_cnt - w0), 64'd0);
        check("midrst_mem_dw2", mem_dw[2], ref_dw(2));

        // handshake: valid held across a busy period
        wait_idle();
        n0 = acc_count;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'd8; req_valid = 1'b1;
        for (int k = 0; k < 20 && acc_count == n0; k++) @(negedge clk);
        acc1 = last_acc;
        check("busy_req_ready", 64'(req_ready), 64'd0);
        req_funct3 = 3'b111; req_addr = 64'h40;
        @(negedge clk);
        req_funct3 = 3'b010; req_addr = 64'd12;
        for (int k = 0; k < 20 && acc_count < n0 + 2; k++) @(negedge clk);
        req_valid = 1'b0;
        check("b2b_accepts", 64'(acc_count - n0), 64'd2);
        check("b2b_spacing", 64'(last_acc - acc1), 64'd3);
        wait_idle();

        // random mix including misaligned and out-of-range addresses
        for (int n = 0; n < 40; n++)
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  64'($urandom_range(0, 71)), {$urandom, $urandom});
        wait_idle();

        for (int i = 0; i < 8; i++) check("final_mem_dw", mem_dw[i], ref_dw(i));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit: the initiator that drives the byte-addressed, 64-bit-wide `Data_Memory` port on behalf of the CPU datapath. Accepts RISC-V load/store requests (byte/half/word/double, signed/unsigned) over a valid/ready handshake and always accesses memory on 8-byte-aligned doublewords. Narrow stores use read-modify-write. Returns an extended load result or an error flag as a one-cycle response pulse.

## Interface
- `MEM_BYTES`, default 64: data memory size in bytes; must be a multiple of 8.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3.
  - Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - Stores: 000 sb, 001 sh, 010 sw, 011 sd.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data; the low `size` bytes are used.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 64: load result; 0 for stores and errors.
- `resp_error` out 1: request rejected; no memory access performed.
- `Mem_Addr` out 64: doubleword base address (`req_addr & ~7`).
- `Write_Data` out 64: merged doubleword to write.
- `MemWrite` out 1: memory commits `Write_Data` at the rising edge while this is high.
- `MemRead` out 1: read enable.
- `Read_Data` in 64: memory read data; combinational from `Mem_Addr` while `MemRead` is high.

## Operation
- Acceptance: a request is taken at a rising edge where `req_valid && req_ready`. The unit latches `addr`, `funct3`, `wdata` and `write`.
- Request inputs are ignored when `req_ready` is 0. There is no response backpressure.
- Decode at acceptance:
  - `size` = 1/2/4/8 bytes from `funct3[1:0]`.
  - `lane = addr[2:0]`.
- Error checks at acceptance. Any of the following sends the FSM to DONE with `resp_error` = 1:
  - `addr % size != 0`;
  - `addr >= MEM_BYTES`;
  - load `funct3` = 111;
  - store `funct3[2]` = 1.
- FSM states: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, DONE.
  - IDLE → DONE: on error.
  - IDLE → LOAD: on a valid load.
  - IDLE → WRITE: on sd.
  - IDLE → RMW_RD: on sb/sh/sw.
  - LOAD → DONE; WRITE → DONE; RMW_RD → RMW_WR → DONE.
  - DONE → IDLE.
- Memory drive:
  - `MemRead` = 1 only in LOAD and RMW_RD.
  - `MemWrite` = 1 only in WRITE and RMW_WR.
  - Both are decoded from the state register only; never both high.
  - `Mem_Addr` = latched base in LOAD, WRITE, RMW_RD and RMW_WR; 0 otherwise.
- LOAD: capture `Read_Data` at the end of the state. Extract bytes `lane .. lane+size-1`. Sign-extend for lb/lh/lw, zero-extend for lbu/lhu/lwu; ld passes all 64 bits.
- WRITE: `Write_Data` = latched `wdata`.
- RMW_RD: capture `Read_Data`.
- RMW_WR: `Write_Data` = captured doubleword with bytes `lane .. lane+size-1` replaced by `wdata` bytes `0 .. size-1`. All other bytes are unchanged.
- `Write_Data` = 0 outside WRITE and RMW_WR.
- DONE: `resp_valid` = 1 for exactly one cycle.
  - `resp_rdata` and `resp_error` are registered on entry to DONE.
  - They hold their value until the next DONE.

## Timing
- Reset (`reset_n` low, asynchronous): state forced to IDLE immediately.
  - `req_ready` = 1.
  - `resp_valid`, `resp_error`, `MemRead`, `MemWrite` = 0.
  - `resp_rdata`, `Mem_Addr`, `Write_Data` = 0.
- Latency is counted from the accept edge E to the cycle in which `resp_valid` is high:
  - error: the cycle after E (1);
  - load, sd: 2 cycles;
  - sb/sh/sw: 3 cycles.
- Back-to-back requests: `req_ready` returns to 1 in the cycle after DONE. Minimum spacing between acceptances is latency + 1.
- Memory commit: the write lands at the edge that ends WRITE or RMW_WR.
- Reset mid-operation:
  - Reset asserted before that edge means no memory write occurs.
  - Any in-flight response is dropped; no `resp_valid` is produced.
- An error request never asserts `MemRead` or `MemWrite`.

## Test plan
- **sd then ld.** Stimulus: sd addr 8, wdata 0x1122334455667788; then ld addr 8.
  - sd: one `MemWrite` cycle with `Mem_Addr` = 8 and `Write_Data` = 0x1122334455667788; `resp_valid` at E+2 with `resp_error` = 0.
  - ld: `resp_rdata` = 0x1122334455667788 at E+2.
- **Load extension**, with bytes 8..15 = 88 77 66 55 44 33 22 11:
  - lb 8 → 0xFFFFFFFFFFFFFF88;
  - lbu 8 → 0x88;
  - lh 14 → 0x1122;
  - lw 12 → 0x11223344;
  - lhu 10 → 0x5566.
- **Narrow store.** Stimulus: sb addr 9, wdata 0xAB, on the same memory contents.
  - `MemRead` with `Mem_Addr` = 8 for one cycle.
  - Next cycle: `MemWrite` with `Write_Data` = 0x112233445566AB88.
  - `resp_valid` at E+3; the other bytes are unchanged.
- **Errors.** Stimulus: lw addr 6, ld addr 64, load `funct3` 111, store `funct3` 100.
  - Each gives `resp_valid` = 1 and `resp_error` = 1 at E+1, with `resp_rdata` = 0.
  - `MemRead` and `MemWrite` stay 0; memory is unchanged.
- **Reset mid-RMW.** Stimulus: drive `reset_n` low while in RMW_RD of an sh to addr 16.
  - `MemWrite` is never asserted; bytes 16..23 are unchanged.
  - No `resp_valid`; `req_ready` = 1 during reset.
- **Handshake.** Stimulus: hold `req_valid` for two queued loads.
  - The second load is accepted only when `req_ready` = 1, one cycle after the first DONE.
  - Inputs changed while busy are ignored.
